irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 171 +++++++++++++++++
 tb/tb_irq_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller
//   Eight-source edge-triggered interrupt controller with a memory-mapped
//   register window. Pending bits are latched on rising source edges and
//   masked. The lowest-numbered active source is presented to the CPU as
//   IRQ plus a 12-bit vector. The request is handshaked through IRQAck and
//   released by an EOI write.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   src[7:0]     interrupt sources (synchronous to clk)
//   dataAddress  CPU word address; window hit when [13:4] == BASE
//   dataOut      CPU write data
//   dataWrEn     CPU write strobe
//   rdData       registered read data (0 when not hit)
//   rdHit        registered read-select for the external data-in mux
//   IRQ          registered interrupt request
//   IRQn         registered vector for the current request
//   IRQAck       CPU acknowledge
//   inService    index of the source being serviced
//
// Register map (offset = dataAddress[3:0])
//   0 MASK  1 PENDING (write-1-clear)  2 EOI  3 STATUS  8..15 VEC[0..7]
module irq_controller #(
   parameter logic [9:0] BASE = 10'h3FF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  src,
   input  logic [13:0] dataAddress,
   input  logic [31:0] dataOut,
   input  logic        dataWrEn,
   output logic [31:0] rdData,
   output logic        rdHit,
   output logic        IRQ,
   output logic [11:0] IRQn,
   input  logic        IRQAck,
   output logic [2:0]  inService
);

   // Encoding is visible to software through STATUS.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ACKED = 2'd2,
      INSVC = 2'd3
   } state_t;

   state_t      state, state_nxt;

   logic [7:0]  mask;
   logic [7:0]  pending;
   logic [7:0]  prev_src;
   logic [11:0] vec [8];

   logic        hit;
   logic [3:0]  off;
   logic        wr;
   logic        wr_mask, wr_pclr, wr_eoi, wr_vec;

   logic [7:0]  active;
   logic        any_active;
   logic [2:0]  winner;
   logic        found;

   logic        load_req;
   logic        ack_take;
   logic [7:0]  pend_set;
   logic [7:0]  pend_clr;
   logic [31:0] rd_sel;

   // Bus decode
   assign hit     = (dataAddress[13:4] == BASE);
   assign off     = dataAddress[3:0];
   assign wr      = hit & dataWrEn;
   assign wr_mask = wr & (off == 4'd0);
   assign wr_pclr = wr & (off == 4'd1);
   assign wr_eoi  = wr & (off == 4'd2);
   assign wr_vec  = wr & off[3];

   // Priority: lowest-numbered active bit wins
   assign active     = pending & mask;
   assign any_active = |active;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (active[i] && !found) begin
            winner = i[2:0];
            found  = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (any_active) state_nxt = REQ;
         REQ:   if (IRQAck)     state_nxt = ACKED;
         ACKED: if (!IRQAck)    state_nxt = INSVC;
         INSVC: if (wr_eoi)     state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // FSM outputs: request load and acknowledge-side pending clear.
   // The request is never withdrawn in REQ, so only IRQAck ends it.
   always_comb begin
      load_req = (state == IDLE) && any_active;
      ack_take = (state == REQ) && IRQAck;
      pend_set = src & ~prev_src;
      pend_clr = wr_pclr ? dataOut[7:0] : '0;
      if (ack_take) pend_clr = pend_clr | (8'b1 << inService);
   end

   // Read mux
   always_comb begin
      rd_sel = '0;
      if (hit) begin
         if (off[3]) begin
            rd_sel = {20'b0, vec[off[2:0]]};
         end else begin
            case (off[2:0])
               3'd0:    rd_sel = {24'b0, mask};
               3'd1:    rd_sel = {24'b0, pending};
               3'd3:    rd_sel = {27'b0, state, inService};
               default: rd_sel = '0;
            endcase
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         IRQ       <= 1'b0;
         IRQn      <= '0;
         inService <= '0;
         rdData    <= '0;
         rdHit     <= 1'b0;
         mask      <= '0;
         pending   <= '0;
         prev_src  <= src;
         for (int unsigned i = 0; i < 8; i++) vec[i] <= '0;
      end else begin
         prev_src <= src;
         // Set is applied after clear so a same-cycle edge wins.
         pending  <= (pending & ~pend_clr) | pend_set;
         if (wr_mask) mask <= dataOut[7:0];
         if (wr_vec)  vec[off[2:0]] <= dataOut[11:0];
         if (load_req) begin
            IRQ       <= 1'b1;
            IRQn      <= vec[winner];
            inService <= winner;
         end else if (ack_take) begin
            IRQ <= 1'b0;
         end
         rdHit  <= hit & ~dataWrEn;
         rdData <= rd_sel;
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

   localparam logic [9:0] BASE = 10'h3FF;

   logic        clk;
   logic        rst;
   logic [7:0]  src;
   logic [13:0] dataAddress;
   logic [31:0] dataOut;
   logic        dataWrEn;
   logic [31:0] rdData;
   logic        rdHit;
   logic        IRQ;
   logic [11:0] IRQn;
   logic        IRQAck;
   logic [2:0]  inService;

   irq_controller #(.BASE(BASE)) dut (
      .clk         (clk),
      .rst         (rst),
      .src         (src),
      .dataAddress (dataAddress),
      .dataOut     (dataOut),
      .dataWrEn    (dataWrEn),
      .rdData      (rdData),
      .rdHit       (rdHit),
      .IRQ         (IRQ),
      .IRQn        (IRQn),
      .IRQAck      (IRQAck),
      .inService   (inService)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: states numbered 0 IDLE, 1 REQ, 2 ACKED, 3 INSVC
   int       m_state;
   bit       m_irq;
   bit [11:0] m_irqn;
   int       m_ins;
   bit [7:0] m_mask, m_pend, m_prev;
   bit [11:0] m_vec [8];
   bit [31:0] m_rd;
   bit       m_rdhit;

   task automatic model_step();
      bit       h;
      int       o;
      bit [31:0] rv;
      bit [7:0] act, clr, edges;
      int       win;
      bit       eoi;
      if (rst) begin
         m_state = 0; m_irq = 0; m_irqn = 0; m_ins = 0;
         m_mask = 0; m_pend = 0; m_prev = src; m_rd = 0; m_rdhit = 0;
         for (int i = 0; i < 8; i++) m_vec[i] = 0;
         return;
      end
      h = (dataAddress[13:4] == BASE);
      o = int'(dataAddress[3:0]);
      rv = 0;
      if (h) begin
         if (o == 0) rv = 32'(m_mask);
         else if (o == 1) rv = 32'(m_pend);
         else if (o == 3) rv = 32'(m_state * 8 + m_ins);
         else if (o >= 8) rv = 32'(m_vec[o - 8]);
      end
      act = m_pend & m_mask;
      win = -1;
      for (int i = 0; i < 8; i++) if (act[i] && win < 0) win = i;
      edges = src & ~m_prev;
      clr = 0;
      if (h && dataWrEn && o == 1) clr = dataOut[7:0];
      if (m_state == 1 && IRQAck) clr[m_ins] = 1'b1;
      eoi = h && dataWrEn && o == 2;
      case (m_state)
         0: if (win >= 0) begin
               m_state = 1; m_irq = 1; m_irqn = m_vec[win]; m_ins = win;
            end
         1: if (IRQAck) begin m_state = 2; m_irq = 0; end
         2: if (!IRQAck) m_state = 3;
         default: if (eoi) m_state = 0;
      endcase
      m_pend = (m_pend & ~clr) | edges;
      if (h && dataWrEn && o == 0) m_mask = dataOut[7:0];
      if (h && dataWrEn && o >= 8) m_vec[o - 8] = dataOut[11:0];
      m_prev  = src;
      m_rd    = rv;
      m_rdhit = h && !dataWrEn;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("mdl_IRQ", 32'(IRQ), 32'(m_irq));
      check("mdl_IRQn", 32'(IRQn), 32'(m_irqn));
      check("mdl_inService", 32'(inService), 32'(m_ins));
      check("mdl_rdHit", 32'(rdHit), 32'(m_rdhit));
      check("mdl_rdData", rdData, m_rd);
   endtask

   task automatic wr(input logic [3:0] o, input logic [31:0] d);
      dataAddress = {BASE, o};
      dataOut     = d;
      dataWrEn    = 1'b1;
      tick();
      dataWrEn    = 1'b0;
      dataAddress = '0;
   endtask

   task automatic rd(input logic [3:0] o);
      dataAddress = {BASE, o};
      dataWrEn    = 1'b0;
      tick();
      dataAddress = '0;
   endtask

   typedef struct {
      logic [3:0]  off;
      logic [31:0] wdata;
      logic        inwin;
      logic        do_wr;
      logic        exp_hit;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [12];

   initial begin
      rst = 1'b1; src = '0; dataAddress = '0; dataOut = '0;
      dataWrEn = 1'b0; IRQAck = 1'b0;
      tick(); tick();
      check("rst_IRQ", 32'(IRQ), 32'h0);
      check("rst_IRQn", 32'(IRQn), 32'h0);
      check("rst_inService", 32'(inService), 32'h0);
      check("rst_rdHit", 32'(rdHit), 32'h0);
      check("rst_rdData", rdData, 32'h0);
      rst = 1'b0;
      tick();

      // Register access table
      tbl[0]  = '{4'd0,  32'hFFFF_FF5A, 1'b1, 1'b1, 1'b1, 32'h5A};
      tbl[1]  = '{4'd11, 32'h1234_5ABC, 1'b1, 1'b1, 1'b1, 32'hABC};
      tbl[2]  = '{4'd8,  32'h0000_0FFF, 1'b1, 1'b1, 1'b1, 32'hFFF};
      tbl[3]  = '{4'd15, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h001};
      tbl[4]  = '{4'd5,  32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h0};
      tbl[5]  = '{4'd2,  32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'h0};
      tbl[6]  = '{4'd3,  32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h0};
      tbl[7]  = '{4'd1,  32'h0000_00FF, 1'b1, 1'b1, 1'b1, 32'h0};
      tbl[8]  = '{4'd7,  32'h0000_0055, 1'b1, 1'b1, 1'b1, 32'h0};
      tbl[9]  = '{4'd0,  32'h0000_0033, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[10] = '{4'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h5A};
      tbl[11] = '{4'd11, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'hABC};
      foreach (tbl[i]) begin
         dataAddress = tbl[i].inwin ? {BASE, tbl[i].off} : {BASE - 10'd1, tbl[i].off};
         if (tbl[i].do_wr) begin
            dataOut  = tbl[i].wdata;
            dataWrEn = 1'b1;
            tick();
            check("tbl_wr_rdHit", 32'(rdHit), 32'h0);
            dataWrEn = 1'b0;
         end
         tick();
         check("tbl_rdHit", 32'(rdHit), 32'(tbl[i].exp_hit));
         check("tbl_rdData", rdData, tbl[i].exp_rd);
      end
      dataAddress = '0;
      tick();

      // Single source, full handshake
      wr(4'd0, 32'h04);
      wr(4'd10, 32'h123);
      src = 8'h04;
      tick();
      check("s1_irq_early", 32'(IRQ), 32'h0);
      src = 8'h00;
      tick();
      check("s1_irq", 32'(IRQ), 32'h1);
      check("s1_irqn", 32'(IRQn), 32'h123);
      check("s1_insvc", 32'(inService), 32'h2);
      IRQAck = 1'b1;
      tick();
      check("s1_ack_irq", 32'(IRQ), 32'h0);
      IRQAck = 1'b0;
      rd(4'd1);
      check("s1_pending", rdData, 32'h0);
      rd(4'd3);
      check("s1_status_insvc", rdData, 32'h1A);
      wr(4'd2, 32'h0);
      rd(4'd3);
      check("s1_status_idle", rdData, 32'h02);

      // Two simultaneous edges; lowest wins, second served after EOI
      wr(4'd0, 32'hFF);
      wr(4'd9, 32'h111);
      wr(4'd13, 32'h555);
      wr(4'd8, 32'h0F0);
      src = 8'h22;
      tick();
      src = 8'h00;
      tick();
      check("s2_irqn", 32'(IRQn), 32'h111);
      check("s2_insvc", 32'(inService), 32'h1);
      IRQAck = 1'b1; tick();
      IRQAck = 1'b0; tick();
      wr(4'd2, 32'h0);
      check("s2_eoi_irq", 32'(IRQ), 32'h0);
      tick();
      check("s2_irq2", 32'(IRQ), 32'h1);
      check("s2_irqn2", 32'(IRQn), 32'h555);

      // New edge during service waits for EOI
      IRQAck = 1'b1; tick();
      IRQAck = 1'b0; tick();
      src = 8'h01; tick();
      src = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("s3_hold_irq", 32'(IRQ), 32'h0);
      end
      wr(4'd2, 32'h0);
      check("s3_eoi_irq", 32'(IRQ), 32'h0);
      tick();
      check("s3_irq", 32'(IRQ), 32'h1);
      check("s3_irqn", 32'(IRQn), 32'h0F0);
      check("s3_insvc", 32'(inService), 32'h0);
      IRQAck = 1'b1; tick();
      IRQAck = 1'b0; tick();
      wr(4'd2, 32'h0);
      tick();

      // Same-cycle edge and write-1-clear: set wins
      wr(4'd0, 32'h0);
      dataAddress = {BASE, 4'd1};
      dataOut = 32'h01;
      dataWrEn = 1'b1;
      src = 8'h01;
      tick();
      dataWrEn = 1'b0;
      rd(4'd1);
      check("s4_set_wins", rdData, 32'h01);
      wr(4'd1, 32'hFF);
      rd(4'd1);
      check("s4_cleared", rdData, 32'h00);
      src = 8'h00;
      tick();

      // Reset mid-request, with a same-cycle write
      wr(4'd0, 32'h10);
      src = 8'h10; tick(); tick();
      check("s5_irq_pre", 32'(IRQ), 32'h1);
      rst = 1'b1;
      dataAddress = {BASE, 4'd0};
      dataOut = 32'hFF;
      dataWrEn = 1'b1;
      tick();
      rst = 1'b0;
      dataWrEn = 1'b0;
      dataAddress = '0;
      check("s5_irq", 32'(IRQ), 32'h0);
      check("s5_irqn", 32'(IRQn), 32'h0);
      rd(4'd3);
      check("s5_status", rdData, 32'h0);
      rd(4'd1);
      check("s5_pending", rdData, 32'h0);
      rd(4'd0);
      check("s5_mask", rdData, 32'h0);
      wr(4'd0, 32'h10);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("s5_no_irq", 32'(IRQ), 32'h0);
      end
      src = 8'h00;
      tick();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         int r;
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 2) == 0) src = 8'($urandom);
         IRQAck = ($urandom_range(0, 2) == 0);
         r = int'($urandom_range(0, 9));
         dataOut = $urandom;
         if (r < 3) begin
            dataAddress = {BASE, 4'($urandom)};
            dataWrEn = 1'b1;
         end else if (r == 3) begin
            dataAddress = {BASE, 4'd2};
            dataWrEn = 1'b1;
         end else if (r < 7) begin
            dataAddress = {BASE, 4'($urandom)};
            dataWrEn = 1'b0;
         end else begin
            dataAddress = 14'($urandom);
            dataWrEn = 1'($urandom);
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
